mitll_ndro_driver: RTL and testbench

Synchronous controller that drives one MITLL NDRO storage cell from a request/response interface. It converts write-0, write-1 and read requests into single-cycle set, reset and clock pulses with enforced hold-off spacing. It captures the cell's out pulse in a read window and checks it against the tracked stored bit. It sits between digital control logic and the NDRO cell model, as the writer/reader counterpart of the cell.

---
 rtl/mitll_ndro_pkg.sv | 25 ++
 rtl/mitll_ndro_if.sv | 21 ++
 rtl/mitll_ndro_holdoff.sv | 26 ++
 rtl/mitll_ndro_driver.sv | 126 ++++++++++++
 tb/tb_mitll_ndro_driver.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mitll_ndro_pkg.sv
// Shared definitions for the MITLL NDRO cell driver: op codes, FSM states and
// the hold-off counter width helper.
package mitll_ndro_pkg;

  localparam logic [1:0] OP_WR0 = 2'b00;
  localparam logic [1:0] OP_WR1 = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_WAIT_OUT,
    ST_RESP
  } fsm_t;

  function automatic int cnt_w(input int gap, input int win);
    int m;
    m = (gap > win) ? gap : win;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mitll_ndro_if.sv
// Request/response bus between digital control logic and the NDRO driver.
interface mitll_ndro_if;

  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic       rsp_valid;
  logic       rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_op,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mitll_ndro_holdoff.sv
// Loadable down-counter timing the INIT gap, write gap and read window.
module mitll_ndro_holdoff #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mitll_ndro_driver.sv
// Drives one MITLL NDRO cell: turns write/read requests into spaced set, reset
// and clk pulses and checks the read-out pulse against the tracked stored bit.
module mitll_ndro_driver
  import mitll_ndro_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int RD_WINDOW  = 4
) (
  input  logic           clk,
  input  logic           reset,
  mitll_ndro_if.slave    bus,
  output logic           set_p,
  output logic           reset_p,
  output logic           clk_p,
  input  logic           out_p,
  output logic           state_q,
  output logic           spur_err
);

  localparam int CW = cnt_w(GAP_CYCLES, RD_WINDOW);

  fsm_t          fsm_q;
  logic [1:0]    op_q;
  logic          init_q;
  logic          capture;
  logic          ho_load;
  logic [CW-1:0] ho_value;
  logic          ho_done;

  // Counter is loaded during the pulse cycle so it expires on the last gap/window cycle
  assign ho_load  = (fsm_q == ST_PULSE);
  assign ho_value = (op_q == OP_RD) ? CW'(RD_WINDOW - 1) : CW'(GAP_CYCLES - 1);

  mitll_ndro_holdoff #(.CNT_W(CW)) u_holdoff (
    .clk   (clk),
    .reset (reset),
    .load  (ho_load),
    .value (ho_value),
    .done  (ho_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q         <= ST_INIT;
      init_q        <= 1'b0;
      set_p         <= 1'b0;
      reset_p       <= 1'b0;
      clk_p         <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 1'b0;
      bus.rsp_err   <= 1'b0;
      state_q       <= 1'b0;
      spur_err      <= 1'b0;
    end else begin
      set_p         <= 1'b0;
      reset_p       <= 1'b0;
      clk_p         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 1'b0;
      bus.rsp_err   <= 1'b0;
      if (out_p && fsm_q != ST_WAIT_OUT) spur_err <= 1'b1;

      case (fsm_q)
        // Cell initialisation reuses the write path as a silent write0
        ST_INIT: begin
          reset_p <= 1'b1;
          op_q    <= OP_WR0;
          init_q  <= 1'b1;
          fsm_q   <= ST_PULSE;
        end
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            op_q          <= bus.req_op;
            case (bus.req_op)
              OP_WR0: begin reset_p <= 1'b1; fsm_q <= ST_PULSE; end
              OP_WR1: begin set_p   <= 1'b1; fsm_q <= ST_PULSE; end
              OP_RD:  begin clk_p   <= 1'b1; fsm_q <= ST_PULSE; end
              default: begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
                fsm_q         <= ST_RESP;
              end
            endcase
          end
        end
        ST_PULSE: begin
          capture <= 1'b0;
          if (op_q == OP_WR1) state_q <= 1'b1;
          else if (op_q == OP_WR0) state_q <= 1'b0;
          fsm_q <= (op_q == OP_RD) ? ST_WAIT_OUT : ST_GAP;
        end
        ST_GAP: begin
          if (ho_done) begin
            if (init_q) begin
              init_q        <= 1'b0;
              bus.req_ready <= 1'b1;
              fsm_q         <= ST_IDLE;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= state_q;
              fsm_q         <= ST_RESP;
            end
          end
        end
        // Out pulse in the final window cycle still counts toward the response
        ST_WAIT_OUT: begin
          if (out_p) capture <= 1'b1;
          if (ho_done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= capture | out_p;
            bus.rsp_err   <= (capture | out_p) != state_q;
            fsm_q         <= ST_RESP;
          end
        end
        ST_RESP: begin
          bus.req_ready <= 1'b1;
          fsm_q         <= ST_IDLE;
        end
        default: fsm_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mitll_ndro_driver.sv
// Self-checking bench for mitll_ndro_driver with a behavioural NDRO cell and a
// stored-bit reference model.
module tb_mitll_ndro_driver;

  localparam int GAP = 2;
  localparam int RD  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_p, reset_p, clk_p, out_p, state_q, spur_err;
  logic cell_en = 1'b1;
  logic stub_out = 1'b0;
  logic cell_out = 1'b0;
  logic cell_bit = 1'b0;
  int   pend = 0;
  int   cyc = 0;
  int   last_p = -1000;
  int   last_min = 0;
  int   mon_viol = 0;
  int   checks = 0;
  int   errors = 0;
  logic model_bit = 1'b0;

  mitll_ndro_if bus();

  mitll_ndro_driver #(.GAP_CYCLES(GAP), .RD_WINDOW(RD)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .set_p    (set_p),
    .reset_p  (reset_p),
    .clk_p    (clk_p),
    .out_p    (out_p),
    .state_q  (state_q),
    .spur_err (spur_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign out_p = cell_en ? cell_out : stub_out;

  // Behavioural NDRO cell: answers a clk pulse two cycles later when holding a 1
  always @(negedge clk) begin
    cell_out = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) cell_out = 1'b1;
    end
    if (reset_p) cell_bit = 1'b0;
    if (set_p) cell_bit = 1'b1;
    if (clk_p && cell_bit) pend = 2;
  end

  // Running invariants: one pulse at a time, pulse spacing, quiet response bus
  always @(negedge clk) begin
    if (reset) begin
      last_p = -1000;
    end else begin
      if ($countones({set_p, reset_p, clk_p}) > 1) mon_viol++;
      if (set_p | reset_p | clk_p) begin
        if (cyc - last_p < last_min) mon_viol++;
        last_p   = cyc;
        last_min = clk_p ? RD + 2 : GAP + 2;
      end
      if (!bus.rsp_valid && (bus.rsp_data || bus.rsp_err)) mon_viol++;
    end
  end

  // Issues one request from a negedge; offsets count cycles after acceptance
  task automatic run_req(input logic [1:0] op, output int pofs, output logic [2:0] pk,
                         output int rofs, output logic d, output logic e);
    int n;
    pofs = -1; pk = 3'b000; rofs = -1; d = 1'b0; e = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    for (int i = 0; i < 20 && rofs < 0; i++) begin
      if (pofs < 0 && (set_p | reset_p | clk_p)) begin
        pofs = i;
        pk   = {set_p, reset_p, clk_p};
      end
      if (bus.rsp_valid) begin
        rofs = i;
        d    = bus.rsp_data;
        e    = bus.rsp_err;
      end
      if (rofs < 0) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int rp_ofs, rdy_ofs, rsp_seen;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({set_p, reset_p, clk_p, bus.req_ready, bus.rsp_valid, bus.rsp_err, spur_err, state_q} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {set_p, reset_p, clk_p, bus.req_ready, bus.rsp_valid, bus.rsp_err, spur_err, state_q});
    end
    reset = 1'b0;
    rp_ofs = -1; rdy_ofs = -1; rsp_seen = 0;
    for (int i = 0; i < 12 && rdy_ofs < 0; i++) begin
      @(negedge clk);
      if (reset_p && rp_ofs < 0) rp_ofs = i;
      if (bus.req_ready) rdy_ofs = i;
      if (bus.rsp_valid) rsp_seen++;
    end
    checks++;
    if (rp_ofs !== 0) begin errors++; $display("FAIL init_reset_p: got offset %0d required 0", rp_ofs); end
    checks++;
    if (rdy_ofs !== GAP + 1) begin errors++; $display("FAIL init_ready: got offset %0d required %0d", rdy_ofs, GAP + 1); end
    checks++;
    if (rsp_seen !== 0) begin errors++; $display("FAIL init_rsp: got %0d responses required 0", rsp_seen); end
    checks++;
    if (state_q !== 1'b0) begin errors++; $display("FAIL init_state: got %b required 0", state_q); end
    model_bit = 1'b0;
  endtask

  task automatic test_write1_read();
    int pofs, rofs; logic [2:0] pk; logic d, e;
    run_req(2'b01, pofs, pk, rofs, d, e);
    model_bit = 1'b1;
    checks++;
    if (pofs !== 0 || pk !== 3'b100) begin errors++; $display("FAIL wr1_pulse: got ofs %0d kind %b required 0 100", pofs, pk); end
    checks++;
    if (rofs !== GAP + 1 || d !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL wr1_rsp: got ofs %0d data %b err %b required %0d 1 0", rofs, d, e, GAP + 1);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || state_q !== 1'b1) begin
      errors++; $display("FAIL wr1_after: got ready %b state %b required 1 1", bus.req_ready, state_q);
    end
    run_req(2'b10, pofs, pk, rofs, d, e);
    checks++;
    if (pofs !== 0 || pk !== 3'b001) begin errors++; $display("FAIL rd1_pulse: got ofs %0d kind %b required 0 001", pofs, pk); end
    checks++;
    if (rofs !== RD + 1 || d !== model_bit || e !== 1'b0) begin
      errors++; $display("FAIL rd1_rsp: got ofs %0d data %b err %b required %0d %b 0", rofs, d, e, RD + 1, model_bit);
    end
  endtask

  task automatic test_write0_read();
    int pofs, rofs; logic [2:0] pk; logic d, e;
    run_req(2'b00, pofs, pk, rofs, d, e);
    model_bit = 1'b0;
    checks++;
    if (pk !== 3'b010 || rofs !== GAP + 1 || d !== 1'b0 || e !== 1'b0) begin
      errors++; $display("FAIL wr0: got kind %b ofs %0d data %b err %b required 010 %0d 0 0", pk, rofs, d, e, GAP + 1);
    end
    run_req(2'b10, pofs, pk, rofs, d, e);
    checks++;
    if (rofs !== RD + 1 || d !== model_bit || e !== 1'b0 || state_q !== model_bit) begin
      errors++; $display("FAIL rd0: got ofs %0d data %b err %b state %b required %0d 0 0 0", rofs, d, e, state_q, RD + 1);
    end
  endtask

  task automatic test_mismatch_spur();
    int pofs, rofs; logic [2:0] pk; logic d, e;
    run_req(2'b01, pofs, pk, rofs, d, e);
    model_bit = 1'b1;
    cell_en = 1'b0;
    stub_out = 1'b0;
    run_req(2'b10, pofs, pk, rofs, d, e);
    checks++;
    if (rofs !== RD + 1 || d !== 1'b0 || e !== 1'b1) begin
      errors++; $display("FAIL mismatch: got ofs %0d data %b err %b required %0d 0 1", rofs, d, e, RD + 1);
    end
    @(negedge clk);
    checks++;
    if (spur_err !== 1'b0) begin errors++; $display("FAIL spur_clean: got %b required 0", spur_err); end
    stub_out = 1'b1;
    @(negedge clk);
    stub_out = 1'b0;
    @(negedge clk);
    checks++;
    if (spur_err !== 1'b1) begin errors++; $display("FAIL spur_set: got %b required 1", spur_err); end
    cell_en = 1'b1;
    run_req(2'b00, pofs, pk, rofs, d, e);
    model_bit = 1'b0;
    run_req(2'b10, pofs, pk, rofs, d, e);
    checks++;
    if (spur_err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b required 1", spur_err); end
  endtask

  task automatic test_reserved();
    int pofs, rofs; logic [2:0] pk; logic d, e;
    run_req(2'b11, pofs, pk, rofs, d, e);
    checks++;
    if (pofs !== -1 || rofs !== 0 || d !== 1'b0 || e !== 1'b1) begin
      errors++; $display("FAIL reserved: got pulse %0d ofs %0d data %b err %b required -1 0 0 1", pofs, rofs, d, e);
    end
    checks++;
    if (state_q !== model_bit) begin errors++; $display("FAIL reserved_state: got %b required %b", state_q, model_bit); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops[3];
    logic [2:0] kinds[$];
    logic       rdat[$];
    logic       acc;
    logic       exp_rd;
    int         idx, nrsp;
    ops[0] = 2'b01; ops[1] = 2'b00; ops[2] = 2'b10;
    idx = 0; nrsp = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = ops[0];
    for (int i = 0; i < 80 && nrsp < 3; i++) begin
      acc = bus.req_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) bus.req_op = ops[idx];
        else bus.req_valid = 1'b0;
      end
      if (set_p | reset_p | clk_p) kinds.push_back({set_p, reset_p, clk_p});
      if (bus.rsp_valid) begin nrsp++; rdat.push_back(bus.rsp_data); end
    end
    bus.req_valid = 1'b0;
    model_bit = 1'b0;
    exp_rd = 1'b0;
    checks++;
    if (idx !== 3 || nrsp !== 3 || kinds.size() !== 3) begin
      errors++; $display("FAIL b2b_count: got acc %0d rsp %0d pulses %0d required 3 3 3", idx, nrsp, kinds.size());
    end else begin
      checks++;
      if (kinds[0] !== 3'b100 || kinds[1] !== 3'b010 || kinds[2] !== 3'b001) begin
        errors++; $display("FAIL b2b_pulses: got %b %b %b required 100 010 001", kinds[0], kinds[1], kinds[2]);
      end
      checks++;
      if (rdat[0] !== 1'b1 || rdat[1] !== 1'b0 || rdat[2] !== exp_rd) begin
        errors++; $display("FAIL b2b_data: got %b %b %b required 1 0 %b", rdat[0], rdat[1], rdat[2], exp_rd);
      end
    end
  endtask

  task automatic test_random();
    int pofs, rofs, exp_pofs, exp_rofs;
    logic [2:0] pk, exp_pk;
    logic d, e, exp_d, exp_e;
    logic [1:0] op;
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_pofs = 0; exp_e = 1'b0;
      case (op)
        2'b00: begin exp_pk = 3'b010; exp_rofs = GAP + 1; model_bit = 1'b0; exp_d = 1'b0; end
        2'b01: begin exp_pk = 3'b100; exp_rofs = GAP + 1; model_bit = 1'b1; exp_d = 1'b1; end
        2'b10: begin exp_pk = 3'b001; exp_rofs = RD + 1; exp_d = model_bit; end
        default: begin exp_pk = 3'b000; exp_pofs = -1; exp_rofs = 0; exp_d = 1'b0; exp_e = 1'b1; end
      endcase
      run_req(op, pofs, pk, rofs, d, e);
      checks++;
      if (pofs !== exp_pofs || pk !== exp_pk) begin
        errors++; $display("FAIL rand_pulse[%0d] op %b: got ofs %0d kind %b required %0d %b", n, op, pofs, pk, exp_pofs, exp_pk);
      end
      checks++;
      if (rofs !== exp_rofs || d !== exp_d || e !== exp_e) begin
        errors++; $display("FAIL rand_rsp[%0d] op %b: got ofs %0d data %b err %b required %0d %b %b",
                           n, op, rofs, d, e, exp_rofs, exp_d, exp_e);
      end
      checks++;
      if (state_q !== model_bit) begin errors++; $display("FAIL rand_state[%0d]: got %b required %b", n, state_q, model_bit); end
    end
  endtask

  task automatic test_reset_mid();
    int n, rp_ofs, rsp_seen, rdy_ofs;
    int pofs, rofs; logic [2:0] pk; logic d, e;
    run_req(2'b01, pofs, pk, rofs, d, e);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state_q !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: got state %b rsp %b required 0 0", state_q, bus.rsp_valid);
    end
    reset = 1'b0;
    model_bit = 1'b0;
    rp_ofs = -1; rdy_ofs = -1; rsp_seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (reset_p && rp_ofs < 0) rp_ofs = i;
      if (bus.req_ready && rdy_ofs < 0) rdy_ofs = i;
      if (bus.rsp_valid) rsp_seen++;
    end
    checks++;
    if (rp_ofs !== 0 || rdy_ofs !== GAP + 1) begin
      errors++; $display("FAIL mid_reinit: got reset_p ofs %0d ready ofs %0d required 0 %0d", rp_ofs, rdy_ofs, GAP + 1);
    end
    checks++;
    if (rsp_seen !== 0 || spur_err !== 1'b0 || state_q !== 1'b0) begin
      errors++; $display("FAIL mid_quiet: got rsp %0d spur %b state %b required 0 0 0", rsp_seen, spur_err, state_q);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (mon_viol !== 0) begin errors++; $display("FAIL invariants: got %0d violations required 0", mon_viol); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    test_reset();
    test_write1_read();
    test_write0_read();
    test_mismatch_spur();
    test_reserved();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
